// File: rtl/word_ring_sched.sv
// word_ring_sched: circulating word ring for message-schedule datapaths.
// A parallel load of STAGES words is streamed from the ring head for ROUNDS
// words over a valid/ready output, with flush and a one-cycle done strobe.
// Optional SHA-256 expansion feedback is built only when the macro
// WORD_RING_SCHED_EXPAND_EN is defined (STAGES==16, WIDTH==32 only);
// otherwise the ring simply rotates.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. The producer holds its data stable while valid is high and
// ready is low. Valid never depends on ready. flush forces out_valid and
// in_ready low combinationally, so no transfer can coincide with a flush.
module word_ring_sched #(
  parameter int STAGES = 16,
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 64,
  localparam int RW    = $clog2(ROUNDS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [STAGES*WIDTH-1:0] din,
  input  logic                    expand,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        dout,
  output logic [RW-1:0]           round,
  input  logic                    flush,
  output logic                    done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];
  logic [RW-1:0]    round_q, round_d;
  logic             expand_q, expand_d;
  logic             done_q, done_d;

  logic             load;
  logic             fire;
  logic             last;
  logic [WIDTH-1:0] feedback;

  // Word written into the ring tail on every accepted output word.
`ifdef WORD_RING_SCHED_EXPAND_EN
  if (STAGES == 16 && WIDTH == 32) begin : g_sha
    logic [31:0] w1, w14, s0, s1, sum;
    assign w1  = stage_q[1];
    assign w14 = stage_q[14];
    assign s0  = {w1[6:0], w1[31:7]} ^ {w1[17:0], w1[31:18]} ^ (w1 >> 3);
    assign s1  = {w14[16:0], w14[31:17]} ^ {w14[18:0], w14[31:19]} ^ (w14 >> 10);
    // Modulo 2^32 sum; carries out of bit 31 are dropped by the width.
    assign sum = s1 + stage_q[9] + s0 + stage_q[0];
    assign feedback = expand_q ? sum : stage_q[0];
  end else begin : g_rot
    $warning("word_ring_sched: expand feedback needs STAGES=16 and WIDTH=32; expand is ignored");
    assign feedback = stage_q[0];
  end
`else
  assign feedback = stage_q[0];
`endif

  // Output-side view of the ring and channel handshakes.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !flush;
    out_valid = (state_q == ST_RUN) && !flush;
    dout      = stage_q[0];
    round     = round_q;
    done      = done_q;
    load      = in_valid && in_ready;
    fire      = out_valid && out_ready;
    last      = (round_q == RW'(ROUNDS - 1));
  end

  // Next-state: flush beats load, load only in IDLE, shift on each accept.
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    expand_d = expand_q;
    done_d   = 1'b0;
    for (int i = 0; i < STAGES; i++) stage_d[i] = stage_q[i];

    if (flush) begin
      state_d = ST_IDLE;
      round_d = '0;
    end else if (load) begin
      for (int i = 0; i < STAGES; i++) stage_d[i] = din[i*WIDTH +: WIDTH];
      round_d  = '0;
      expand_d = expand;
      state_d  = ST_RUN;
    end else if (fire) begin
      for (int i = 0; i < STAGES - 1; i++) stage_d[i] = stage_q[i+1];
      stage_d[STAGES-1] = feedback;
      if (last) begin
        state_d = ST_IDLE;
        round_d = '0;
        done_d  = 1'b1;
      end else begin
        round_d = round_q + RW'(1);
      end
    end
  end

  // State, ring and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      round_q  <= '0;
      expand_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      expand_q <= expand_d;
      done_q   <= done_d;
      for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
    end
  end

endmodule

// File: tb/tb_word_ring_sched.sv
// Testbench for word_ring_sched: a small rotate-only instance (4x8, 6 rounds)
// driven from a vector table, hand sequences and random traffic, plus a
// default-sized instance loaded with the SHA-256 "abc" block.
module tb_word_ring_sched;

  localparam int S_ST = 4;
  localparam int S_W  = 8;
  localparam int S_R  = 6;
  localparam int S_RW = $clog2(S_R + 1);
  localparam int B_ST = 16;
  localparam int B_W  = 32;
  localparam int B_R  = 64;
  localparam int B_RW = $clog2(B_R + 1);

`ifdef WORD_RING_SCHED_EXPAND_EN
  localparam bit SHA_BUILT = 1'b1;
`else
  localparam bit SHA_BUILT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // small instance
  logic                 s_in_valid, s_in_ready, s_expand, s_out_valid, s_out_ready, s_flush, s_done;
  logic [S_ST*S_W-1:0]  s_din;
  logic [S_W-1:0]       s_dout;
  logic [S_RW-1:0]      s_round;

  // default-size instance
  logic                 b_in_valid, b_in_ready, b_expand, b_out_valid, b_out_ready, b_flush, b_done;
  logic [B_ST*B_W-1:0]  b_din;
  logic [B_W-1:0]       b_dout;
  logic [B_RW-1:0]      b_round;

  word_ring_sched #(.STAGES(S_ST), .WIDTH(S_W), .ROUNDS(S_R)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .din(s_din),
    .expand(s_expand), .out_valid(s_out_valid), .out_ready(s_out_ready), .dout(s_dout),
    .round(s_round), .flush(s_flush), .done(s_done)
  );

  word_ring_sched #(.STAGES(B_ST), .WIDTH(B_W), .ROUNDS(B_R)) u_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
    .expand(b_expand), .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout),
    .round(b_round), .flush(b_flush), .done(b_done)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference word sequence for one load: the loaded words, then either the
  // SHA-256 recurrence or a repeat of the sequence modulo the ring depth.
  function automatic void ref_seq(input logic [511:0] d, input int stages, input int width,
                                  input int rounds, input bit sha, output logic [31:0] w[$]);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    w = {};
    for (int k = 0; k < rounds; k++) begin
      if (k < stages)  w.push_back(32'(d >> (k * width)) & mask);
      else if (sha)    w.push_back(sig1(w[k-2]) + w[k-7] + sig0(w[k-15]) + w[k-16]);
      else             w.push_back(w[k-stages]);
    end
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] din;
    logic        ir;
    logic        ov;
    logic [7:0]  dout;
    logic [2:0]  rnd;
    logic        dn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic ordy, input logic fl, input logic [31:0] din,
                              input logic ir, input logic ov, input logic [7:0] dout,
                              input logic [2:0] rnd, input logic dn);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.din = din;
    v.ir = ir; v.ov = ov; v.dout = dout; v.rnd = rnd; v.dn = dn;
    return v;
  endfunction

  // random-phase model state
  bit          m_run;
  bit          m_done;
  int          m_k;
  logic [31:0] m_seq[$];
  logic [31:0] w_exp[$];
  int          got;
  int          cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    localparam logic [31:0] D1 = 32'h4433_2211;
    localparam logic [31:0] D2 = 32'hDDCC_BBAA;

    // rotate: six words then done, in_ready again
    vecs.push_back(mk(1, 1, 0, D1, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h22, 1, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h33, 2, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h44, 3, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h11, 4, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h22, 5, 0));
    vecs.push_back(mk(0, 1, 0, D1, 1, 0, 8'h33, 0, 1));
    vecs.push_back(mk(0, 1, 0, D1, 1, 0, 8'h33, 0, 0));
    // back-pressure: three stalled cycles on the second word
    vecs.push_back(mk(1, 1, 0, D1, 1, 0, 8'h33, 0, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 0, 0, D1, 0, 1, 8'h22, 1, 0));
    vecs.push_back(mk(0, 0, 0, D1, 0, 1, 8'h22, 1, 0));
    vecs.push_back(mk(0, 0, 0, D1, 0, 1, 8'h22, 1, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h22, 1, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h33, 2, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h44, 3, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h11, 4, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h22, 5, 0));
    vecs.push_back(mk(0, 1, 0, D1, 1, 0, 8'h33, 0, 1));
    // flush at round 2, then flush beating a load, then a fresh load
    vecs.push_back(mk(1, 1, 0, D2, 1, 0, 8'h33, 0, 0));
    vecs.push_back(mk(0, 1, 0, D2, 0, 1, 8'hAA, 0, 0));
    vecs.push_back(mk(0, 1, 0, D2, 0, 1, 8'hBB, 1, 0));
    vecs.push_back(mk(0, 1, 1, D2, 0, 0, 8'hCC, 2, 0));
    vecs.push_back(mk(0, 1, 0, D2, 1, 0, 8'hCC, 0, 0));
    vecs.push_back(mk(1, 1, 1, D1, 0, 0, 8'hCC, 0, 0));
    vecs.push_back(mk(0, 1, 0, D1, 1, 0, 8'hCC, 0, 0));
    vecs.push_back(mk(1, 1, 0, D1, 1, 0, 8'hCC, 0, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h22, 1, 0));
    vecs.push_back(mk(0, 1, 0, D1, 0, 1, 8'h33, 2, 0));

    // reset and reset-state checks
    rst = 1'b1;
    s_in_valid = 0; s_out_ready = 0; s_flush = 0; s_expand = 0; s_din = '0;
    b_in_valid = 0; b_out_ready = 0; b_flush = 0; b_expand = 0; b_din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", s_in_ready, 1);
    check("reset out_valid", s_out_valid, 0);
    check("reset round", s_round, 0);
    check("reset done", s_done, 0);
    check("reset dout", s_dout, 0);
    check("reset big in_ready", b_in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // table-driven phase
    foreach (vecs[i]) begin
      s_in_valid  = vecs[i].iv;
      s_out_ready = vecs[i].ordy;
      s_flush     = vecs[i].fl;
      s_din       = vecs[i].din;
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i), s_in_ready, vecs[i].ir);
      check($sformatf("vec%0d out_valid", i), s_out_valid, vecs[i].ov);
      check($sformatf("vec%0d dout", i), s_dout, vecs[i].dout);
      check($sformatf("vec%0d round", i), s_round, vecs[i].rnd);
      check($sformatf("vec%0d done", i), s_done, vecs[i].dn);
      @(posedge clk); #1;
    end

    // async reset in the middle of a run at round 3
    s_in_valid = 0; s_out_ready = 1; s_flush = 0;
    @(negedge clk);
    check("pre-reset round", s_round, 3);
    check("pre-reset dout", s_dout, 8'h44);
    check("pre-reset out_valid", s_out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async out_valid", s_out_valid, 0);
    check("async round", s_round, 0);
    check("async done", s_done, 0);
    check("async in_ready", s_in_ready, 1);
    check("async dout", s_dout, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // randomized phase against the sequence model
    m_run = 0; m_done = 0; m_k = 0;
    for (int c = 0; c < 2000; c++) begin
      s_in_valid  = 1'($urandom_range(0, 1));
      s_out_ready = ($urandom_range(0, 3) != 0);
      s_flush     = ($urandom_range(0, 39) == 0);
      s_expand    = 1'($urandom_range(0, 1));
      s_din       = $urandom;
      @(negedge clk);
      check("rnd in_ready", s_in_ready, !m_run && !s_flush);
      check("rnd out_valid", s_out_valid, m_run && !s_flush);
      check("rnd done", s_done, m_done);
      if (m_run && !s_flush) begin
        check("rnd dout", s_dout, m_seq[m_k][S_W-1:0]);
        check("rnd round", s_round, m_k);
      end
      m_done = 0;
      if (s_flush) begin
        m_run = 0;
      end else if (!m_run && s_in_valid) begin
        ref_seq({480'b0, s_din}, S_ST, S_W, S_R, 1'b0, m_seq);
        m_run = 1;
        m_k = 0;
      end else if (m_run && s_out_ready) begin
        m_k++;
        if (m_k == S_R) begin
          m_run = 0;
          m_done = 1;
        end
      end
      @(posedge clk); #1;
    end
    s_in_valid = 0; s_flush = 0;

    // SHA-256 "abc" block on the default-size instance
    b_din = '0;
    b_din[0*32 +: 32]  = 32'h6162_6380;
    b_din[15*32 +: 32] = 32'h0000_0018;
    b_expand = 1; b_out_ready = 1; b_in_valid = 1;
    @(negedge clk);
    check("big load in_ready", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 0;
    ref_seq(b_din, B_ST, B_W, B_R, SHA_BUILT, w_exp);
    got = 0;
    cyc = 0;
    while (got < B_R && cyc < 200) begin
      @(negedge clk);
      if (b_out_valid) begin
        check($sformatf("big word%0d", got), b_dout, w_exp[got]);
        check($sformatf("big round%0d", got), b_round, got);
        if (got == 16) check("big word16 const", b_dout, 32'h6162_6380);
        if (got == 17) check("big word17 const", b_dout, SHA_BUILT ? 32'h000F_0000 : 32'h0000_0000);
        got++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    check("big word count", got, B_R);
    @(negedge clk);
    check("big done pulse", b_done, 1);
    check("big out_valid after", b_out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("big done cleared", b_done, 0);
    check("big in_ready after", b_in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
